// File: rtl/memory_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_controller_pkg
// Brief    : Shared constants, length encoding and state type for the
//            byte-serial memory controller.
// Revision : 1.0
// ============================================================================
package memory_controller_pkg;

  localparam int LSB_CAP_BIT = 3;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  // Reserved encoding 2'b11 is treated as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : memory_controller
// Brief    : Byte-serial sequencer sharing one 8-bit RAM bus between LSB
//            load/store requests and instruction fetch.
// Revision : 1.0
// ============================================================================
module memory_controller #(
  parameter int LSB_CAP_BIT = memory_controller_pkg::LSB_CAP_BIT
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   inst_req,
  input  logic [31:0]            inst_addr,
  output logic                   inst_ready,
  output logic [31:0]            inst_data,
  output logic                   inst_need_work,
  input  logic                   lsb_req,
  input  logic [LSB_CAP_BIT-1:0] lsb_pos,
  input  logic                   lsb_ls,
  input  logic [1:0]             lsb_len,
  input  logic [31:0]            lsb_addr,
  input  logic [31:0]            lsb_val,
  output logic                   mem_finished,
  output logic [31:0]            mem_val,
  output logic [LSB_CAP_BIT-1:0] mem_pos,
  output logic                   mem_busy,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr
);
  import memory_controller_pkg::*;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [2:0]             r_k;
  logic [2:0]             r_n;
  logic [31:0]            r_addr;
  logic [31:0]            r_val;
  logic [31:0]            r_data;
  logic [LSB_CAP_BIT-1:0] r_pos;
  logic                   r_orphan;

  logic                   w_accept_lsb;
  logic                   w_accept_inst;
  logic                   w_done;
  logic [1:0]             w_idx;
  logic [31:0]            w_assembled;

  // A fetch whose result is on inst_ready this cycle is no longer pending.
  assign inst_need_work = inst_req && !inst_ready;
  assign mem_busy       = (r_state != S_IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in)      r_state <= S_IDLE;
    else if (rdy_in) r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_accept_lsb  = 1'b0;
    w_accept_inst = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!clear) begin
          if (lsb_req) begin
            w_accept_lsb = 1'b1;
            w_next_state = lsb_ls ? S_STORE : S_LOAD;
          end else if (inst_req && !inst_ready) begin
            w_accept_inst = 1'b1;
            w_next_state  = S_FETCH;
          end
        end
      end
      S_LOAD, S_FETCH: begin
        if (clear) begin
          w_next_state = S_IDLE;
        end else if (r_k == r_n) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_STORE: begin
        if (r_k == r_n - 3'd1) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // RAM read data lags the address by one cycle, so slot k holds byte k-1.
  always_comb begin
    w_idx       = r_k[1:0] - 2'd1;
    w_assembled = r_data;
    w_assembled[{w_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    mem_a    = 32'd0;
    mem_wr   = 1'b0;
    mem_dout = 8'd0;
    if (r_state != S_IDLE && r_k < r_n) begin
      mem_a = r_addr + {29'd0, r_k};
      if (r_state == S_STORE) begin
        mem_wr   = 1'b1;
        mem_dout = r_val[{r_k[1:0], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_k          <= 3'd0;
      r_n          <= 3'd0;
      r_addr       <= 32'd0;
      r_val        <= 32'd0;
      r_data       <= 32'd0;
      r_pos        <= '0;
      r_orphan     <= 1'b0;
      mem_finished <= 1'b0;
      mem_val      <= 32'd0;
      mem_pos      <= '0;
      inst_ready   <= 1'b0;
      inst_data    <= 32'd0;
    end else if (rdy_in) begin
      mem_finished <= 1'b0;
      inst_ready   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept_lsb || w_accept_inst) begin
            r_k      <= 3'd0;
            r_data   <= 32'd0;
            r_orphan <= 1'b0;
          end
          if (w_accept_lsb) begin
            r_addr <= lsb_addr;
            r_val  <= lsb_val;
            r_pos  <= lsb_pos;
            r_n    <= len_bytes(lsb_len);
          end else if (w_accept_inst) begin
            r_addr <= inst_addr;
            r_n    <= 3'd4;
          end
        end
        S_LOAD, S_FETCH: begin
          if (!clear) begin
            if (r_k != 3'd0) r_data <= w_assembled;
            r_k <= r_k + 3'd1;
            if (w_done && r_state == S_LOAD) begin
              mem_finished <= 1'b1;
              mem_val      <= w_assembled;
              mem_pos      <= r_pos;
            end else if (w_done) begin
              inst_ready <= 1'b1;
              inst_data  <= w_assembled;
            end
          end
        end
        S_STORE: begin
          r_k <= r_k + 3'd1;
          if (clear) r_orphan <= 1'b1;
          // A flushed store still finishes its bytes but reports nothing.
          if (w_done && !r_orphan && !clear) begin
            mem_finished <= 1'b1;
            mem_pos      <= r_pos;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_controller
// Brief    : Scoreboard bench for memory_controller with a byte RAM model.
// Revision : 1.0
// ============================================================================
module tb_memory_controller;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        inst_need_work;
  logic        lsb_req;
  logic [2:0]  lsb_pos;
  logic        lsb_ls;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr, lsb_val;
  logic        mem_finished;
  logic [31:0] mem_val;
  logic [2:0]  mem_pos;
  logic        mem_busy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  memory_controller #(.LSB_CAP_BIT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_need_work(inst_need_work),
    .lsb_req(lsb_req), .lsb_pos(lsb_pos), .lsb_ls(lsb_ls), .lsb_len(lsb_len),
    .lsb_addr(lsb_addr), .lsb_val(lsb_val),
    .mem_finished(mem_finished), .mem_val(mem_val), .mem_pos(mem_pos),
    .mem_busy(mem_busy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Byte RAM, frozen together with the controller when rdy_in is low.
  logic [7:0] ram [0:4095];
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= ram[mem_a[11:0]];
    end
  end

  typedef struct {
    int          kind;   // 0 = mem_finished, 1 = inst_ready
    int          cyc;
    logic [31:0] val;
    logic [2:0]  pos;
    bit          chk_val;
  } ev_t;
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  ev_t exp_ev[$];
  wr_t exp_wr[$];
  ev_t m_ev;
  wr_t m_wr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input logic [31:0] v,
                         input logic [2:0] p, input bit cv);
    ev_t e;
    e.kind = kind; e.cyc = c; e.val = v; e.pos = p; e.chk_val = cv;
    exp_ev.push_back(e);
  endtask

  task automatic push_wr(input int c, input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    exp_wr.push_back(w);
  endtask

  // Monitor: one evaluation per active (unfrozen) cycle.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in) begin
      if (mem_wr) begin
        if (exp_wr.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          m_wr = exp_wr.pop_front();
          check("wr_cycle", cyc, m_wr.cyc);
          check("wr_addr", mem_a, m_wr.addr);
          check("wr_data", {24'd0, mem_dout}, {24'd0, m_wr.data});
        end
      end
      if (mem_finished || inst_ready) begin
        if (exp_ev.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
        else begin
          m_ev = exp_ev.pop_front();
          check("ev_kind", {31'd0, inst_ready}, m_ev.kind);
          check("ev_cycle", cyc, m_ev.cyc);
          if (m_ev.kind == 0) begin
            check("mem_pos", {29'd0, mem_pos}, {29'd0, m_ev.pos});
            if (m_ev.chk_val) check("mem_val", mem_val, m_ev.val);
          end else begin
            check("inst_data", inst_data, m_ev.val);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      if (exp_ev.size() == 0 && exp_wr.size() == 0 && !mem_busy) break;
      tick();
    end
    check({name, "_drain_timeout"}, {31'd0, (i == 40)}, 32'd0);
    tick();
    tick();
  endtask

  task automatic wait_inst_ready(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      if (inst_ready) break;
      tick();
    end
    check({name, "_fetch_timeout"}, {31'd0, (i == 40)}, 32'd0);
    check({name, "_need_work_on_ready"}, {31'd0, inst_need_work}, 32'd0);
    inst_req = 1'b0;
  endtask

  int c;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22;
    ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
    ram[12'h400] <= 8'hA1; ram[12'h401] <= 8'hB2;
    ram[12'h402] <= 8'hC3; ram[12'h403] <= 8'hD4;
    ram[12'h010] <= 8'h5A;

    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    inst_req = 1'b0; inst_addr = 32'd0;
    lsb_req = 1'b0; lsb_pos = 3'd0; lsb_ls = 1'b0; lsb_len = 2'b00;
    lsb_addr = 32'd0; lsb_val = 32'd0;
    repeat (3) tick();

    check("rst_mem_finished", {31'd0, mem_finished}, 32'd0);
    check("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
    check("rst_mem_busy", {31'd0, mem_busy}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_val", mem_val, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    rst_in = 1'b0;
    tick();

    // LW 0x100
    c = cyc;
    lsb_req = 1'b1; lsb_pos = 3'd5; lsb_ls = 1'b0; lsb_len = 2'b10; lsb_addr = 32'h100;
    push_ev(0, c + 6, 32'h44332211, 3'd5, 1'b1);
    tick(); lsb_req = 1'b0;
    check("lw_busy_c1", {31'd0, mem_busy}, 32'd1);
    drain("lw");

    // SH 0x201 <- 0xABCD
    c = cyc;
    lsb_req = 1'b1; lsb_pos = 3'd2; lsb_ls = 1'b1; lsb_len = 2'b01;
    lsb_addr = 32'h201; lsb_val = 32'h0000ABCD;
    push_wr(c + 1, 32'h201, 8'hCD);
    push_wr(c + 2, 32'h202, 8'hAB);
    push_ev(0, c + 3, 32'd0, 3'd2, 1'b0);
    tick(); lsb_req = 1'b0;
    drain("sh");

    // LB and fetch in the same cycle: LB first, fetch follows
    c = cyc;
    lsb_req = 1'b1; lsb_pos = 3'd1; lsb_ls = 1'b0; lsb_len = 2'b00; lsb_addr = 32'h10;
    inst_req = 1'b1; inst_addr = 32'h400;
    push_ev(0, c + 3, 32'h0000005A, 3'd1, 1'b1);
    push_ev(1, c + 9, 32'hD4C3B2A1, 3'd0, 1'b1);
    tick(); lsb_req = 1'b0;
    tick();
    check("tie_need_work", {31'd0, inst_need_work}, 32'd1);
    wait_inst_ready("tie");
    drain("tie");

    // Flush during the second byte of a LW
    c = cyc;
    lsb_req = 1'b1; lsb_pos = 3'd3; lsb_ls = 1'b0; lsb_len = 2'b10; lsb_addr = 32'h100;
    tick(); lsb_req = 1'b0;
    tick(); clear = 1'b1;
    tick(); clear = 1'b0;
    check("lw_clear_busy", {31'd0, mem_busy}, 32'd0);
    check("lw_clear_finished", {31'd0, mem_finished}, 32'd0);
    drain("lw_clear");

    // Flush during SW to 0x30000: store completes silently
    c = cyc;
    lsb_req = 1'b1; lsb_pos = 3'd4; lsb_ls = 1'b1; lsb_len = 2'b10;
    lsb_addr = 32'h30000; lsb_val = 32'hDEADBEEF;
    push_wr(c + 1, 32'h30000, 8'hEF);
    push_wr(c + 2, 32'h30001, 8'hBE);
    push_wr(c + 3, 32'h30002, 8'hAD);
    push_wr(c + 4, 32'h30003, 8'hDE);
    tick(); lsb_req = 1'b0;
    tick(); clear = 1'b1;
    tick(); clear = 1'b0;
    check("sw_clear_busy_c3", {31'd0, mem_busy}, 32'd1);
    tick();
    check("sw_clear_busy_c4", {31'd0, mem_busy}, 32'd1);
    tick();
    check("sw_clear_busy_c5", {31'd0, mem_busy}, 32'd0);
    drain("sw_clear");

    // LH 0x102 after the flush
    c = cyc;
    lsb_req = 1'b1; lsb_pos = 3'd6; lsb_ls = 1'b0; lsb_len = 2'b01; lsb_addr = 32'h102;
    push_ev(0, c + 4, 32'h00004433, 3'd6, 1'b1);
    tick(); lsb_req = 1'b0;
    drain("lh");

    // Fetch with rdy_in low for 3 cycles
    c = cyc;
    inst_req = 1'b1; inst_addr = 32'h400;
    push_ev(1, c + 9, 32'hD4C3B2A1, 3'd0, 1'b1);
    tick(); tick(); tick();
    rdy_in = 1'b0;
    tick(); tick(); tick();
    rdy_in = 1'b1;
    wait_inst_ready("stall");
    drain("stall");

    check("ev_queue_empty", exp_ev.size(), 32'd0);
    check("wr_queue_empty", exp_wr.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
